bcd_down_timer: RTL and testbench

Loadable multi-digit BCD countdown timer: the down-counting counterpart of the team's mod-(TOP+1) up-counter. It decrements on a qualified tick and borrows between digits, wrapping each digit 0 -> TOP. It raises a done pulse when the whole value reaches zero. It sits behind the prescaler in the clock/timer datapath; `tick` is the prescaler carry pulse, and `q` feeds the display decoders.

---
 rtl/bcd_down_timer.sv | 131 +++++++++++++
 tb/tb_bcd_down_timer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_down_timer.sv
// rtl/bcd_down_timer.sv - loadable multi-digit BCD countdown timer with done pulse
module bcd_down_timer #(
  parameter int DIGITS = 4,
  parameter int TOP    = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                start,
  input  logic                stop,
  output logic [4*DIGITS-1:0] q,
  output logic                running,
  output logic                done,
  output logic [1:0]          state
);

  localparam int W = 4 * DIGITS;
  localparam logic [3:0] TOP_D = 4'(TOP);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t          st;
  logic [W-1:0]    load_clamped;
  logic [W-1:0]    q_dec;
  logic [DIGITS-1:0] borrow;
  logic            q_zero;
  logic            q_one;

  // Digit 0 always takes the borrow; the chain stops at the first non-zero digit.
  assign borrow[0] = 1'b1;

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      logic [3:0] d_cur;
      logic [3:0] d_ld;

      assign d_cur = q[4*i +: 4];
      assign d_ld  = load_val[4*i +: 4];

      // Out-of-range preset digits saturate at TOP so q always stays legal.
      assign load_clamped[4*i +: 4] = (d_ld > TOP_D) ? TOP_D : d_ld;

      // A borrowed-from zero digit wraps to TOP; otherwise it simply decrements.
      assign q_dec[4*i +: 4] = !borrow[i]        ? d_cur :
                               (d_cur == 4'd0)   ? TOP_D :
                                                   d_cur - 4'd1;

      if (i < DIGITS - 1) begin : g_chain
        assign borrow[i+1] = borrow[i] && (d_cur == 4'd0);
      end
    end
  endgenerate

  // Terminal detection looks at the pre-decrement value so done lands on the zeroing edge.
  assign q_zero = (q == '0);
  assign q_one  = (q == W'(1));

  assign state = st;

  // Control FSM: priority stop > load > start > tick; all outputs registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st      <= IDLE;
      q       <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (st)
        IDLE: begin
          if (stop) begin
            // stop has nothing to abort while idle
          end else if (load) begin
            q <= load_clamped;
          end else if (start) begin
            if (q_zero) begin
              st   <= DONE;
              done <= 1'b1;
            end else begin
              st      <= RUN;
              running <= 1'b1;
            end
          end
        end
        RUN: begin
          if (stop) begin
            st      <= PAUSE;
            running <= 1'b0;
          end else if (tick) begin
            if (q_one) begin
              q       <= '0;
              st      <= DONE;
              running <= 1'b0;
              done    <= 1'b1;
            end else begin
              q <= q_dec;
            end
          end
        end
        PAUSE: begin
          if (stop) begin
            st <= IDLE;
          end else if (load) begin
            q <= load_clamped;
          end else if (start) begin
            st      <= RUN;
            running <= 1'b1;
          end
        end
        DONE: begin
          if (load) begin
            q  <= load_clamped;
            st <= IDLE;
          end
        end
        default: begin
          st      <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_down_timer.sv
// tb/tb_bcd_down_timer.sv - self-checking bench for bcd_down_timer
module tb_bcd_down_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        tick = 0, load = 0, start = 0, stop = 0;
  logic [15:0] load_val = '0;
  logic [15:0] q;
  logic        running, done;
  logic [1:0]  state;

  logic        tick2 = 0, load2 = 0, start2 = 0, stop2 = 0;
  logic [7:0]  load_val2 = '0;
  logic [7:0]  q2;
  logic        running2, done2;
  logic [1:0]  state2;

  int checks = 0;
  int errors = 0;

  bcd_down_timer #(.DIGITS(4), .TOP(9)) dut (
    .clk(clk), .reset(reset), .tick(tick), .load(load), .load_val(load_val),
    .start(start), .stop(stop), .q(q), .running(running), .done(done), .state(state)
  );

  bcd_down_timer #(.DIGITS(2), .TOP(5)) dut2 (
    .clk(clk), .reset(reset), .tick(tick2), .load(load2), .load_val(load_val2),
    .start(start2), .stop(stop2), .q(q2), .running(running2), .done(done2), .state(state2)
  );

  always #5 clk = ~clk;

  // Model: the count is an ordinary integer in base TOP+1; decrement is n-1.
  localparam int B = 10;
  int n  = 0;
  int ms = 0;
  bit md = 0;

  function automatic logic [15:0] to_digits(input int v);
    logic [15:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % B);
      t = t / B;
    end
    return r;
  endfunction

  function automatic int clamp_val(input logic [15:0] lv);
    int v;
    int d;
    v = 0;
    for (int i = 3; i >= 0; i--) begin
      d = int'(lv[4*i +: 4]);
      if (d > B - 1) d = B - 1;
      v = v * B + d;
    end
    return v;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      n = 0; ms = 0; md = 0;
    end else begin
      md = 0;
      case (ms)
        0: if (!stop) begin
             if (load) n = clamp_val(load_val);
             else if (start) begin
               if (n == 0) begin ms = 3; md = 1; end
               else ms = 1;
             end
           end
        1: if (stop) ms = 2;
           else if (tick) begin
             n = n - 1;
             if (n == 0) begin ms = 3; md = 1; end
           end
        2: if (stop) ms = 0;
           else if (load) n = clamp_val(load_val);
           else if (start) ms = 1;
        default: if (load) begin n = clamp_val(load_val); ms = 0; end
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, compare the main DUT against the model on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      check("model_q", 32'(q), 32'(to_digits(n)));
      check("model_state", 32'(state), 32'(ms));
      check("model_running", 32'(running), 32'(ms == 1));
      check("model_done", 32'(done), 32'(md));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    tick = 0; load = 0; start = 0; stop = 0;
    tick2 = 0; load2 = 0; start2 = 0; stop2 = 0;
  endtask

  initial begin
    reset = 1'b1;
    #12;
    check("rst_q", 32'(q), 32'h0);
    check("rst_state", 32'(state), 32'h0);
    check("rst_running", 32'(running), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    step();

    // Borrow across two zero digits
    load = 1; load_val = 16'h0100; step();
    check("load_0100", 32'(q), 32'h0100);
    start = 1; step();
    check("run_state", 32'(state), 32'h1);
    tick = 1; step();
    check("tick1_0099", 32'(q), 32'h0099);
    check("running1", 32'(running), 32'h1);
    tick = 1; step();
    check("tick2_0098", 32'(q), 32'h0098);
    check("running2", 32'(running), 32'h1);
    stop = 1; step();
    stop = 1; step();
    check("idle_after_2stop", 32'(state), 32'h0);

    // Clamp on a 4-digit load
    load = 1; load_val = 16'hFFFF; step();
    check("clamp_9999", 32'(q), 32'h9999);

    // Count down to zero
    load = 1; load_val = 16'h0003; step();
    start = 1; step();
    tick = 1; step(); check("cd_0002", 32'(q), 32'h0002);
    tick = 1; step(); check("cd_0001", 32'(q), 32'h0001);
    check("cd_done_low", 32'(done), 32'h0);
    tick = 1; step();
    check("cd_0000", 32'(q), 32'h0000);
    check("cd_done_pulse", 32'(done), 32'h1);
    check("cd_state_done", 32'(state), 32'h3);
    tick = 1; step();
    check("cd_done_cleared", 32'(done), 32'h0);
    tick = 1; step();
    check("cd_q_held", 32'(q), 32'h0000);
    check("cd_state_held", 32'(state), 32'h3);

    // Stop with a simultaneous tick discards the tick
    load = 1; load_val = 16'h0010; step();
    check("done_load_idle", 32'(state), 32'h0);
    start = 1; step();
    stop = 1; tick = 1; step();
    check("pause_q", 32'(q), 32'h0010);
    check("pause_state", 32'(state), 32'h2);
    start = 1; step();
    tick = 1; step();
    check("resume_0009", 32'(q), 32'h0009);
    stop = 1; step();
    stop = 1; step();
    check("abort_idle", 32'(state), 32'h0);

    // Start at zero goes straight to DONE
    load = 1; load_val = 16'h0000; step();
    start = 1; step();
    check("zero_start_state", 32'(state), 32'h3);
    check("zero_start_done", 32'(done), 32'h1);
    step();
    check("zero_start_done_once", 32'(done), 32'h0);
    load = 1; load_val = 16'h0005; step();
    check("done_reload_q", 32'(q), 32'h0005);
    check("done_reload_state", 32'(state), 32'h0);
    start = 1; step();
    load = 1; load_val = 16'h0500; step();
    check("run_load_ignored", 32'(q), 32'h0005);

    // 2-digit, TOP=5 instance
    load2 = 1; load_val2 = 8'h30; step();
    start2 = 1; step();
    tick2 = 1; step();
    check("d2_tick_25", 32'(q2), 32'h25);
    stop2 = 1; step();
    load2 = 1; load_val2 = 8'h7A; step();
    check("d2_clamp_55", 32'(q2), 32'h55);

    // Asynchronous reset mid-RUN
    stop = 1; step();
    load = 1; load_val = 16'h0042; step();
    start = 1; step();
    check("pre_rst_q", 32'(q), 32'h0042);
    check("pre_rst_run", 32'(running), 32'h1);
    #1;
    reset = 1'b1;
    #1;
    check("async_rst_q", 32'(q), 32'h0);
    check("async_rst_state", 32'(state), 32'h0);
    check("async_rst_running", 32'(running), 32'h0);
    check("async_rst_done", 32'(done), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
